// File: rtl/word_narrow_unit.sv
// word_narrow_unit
// Streaming 32-to-16-bit narrowing stage. Each accepted word is range-checked
// (signed or unsigned), then truncated or saturated to 16 bits with a per-word
// overflow flag. An output register plus one skid register decouple the input
// handshake from downstream backpressure. A saturating counter tallies
// accepted words that overflowed.
module word_narrow_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    // Occupancy of the output/skid buffer pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;
    logic [OUT_W-1:0]   skid_data_q, skid_data_d;
    logic               skid_ovf_q, skid_ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_fire;
    logic               out_fire;
    logic [OUT_W:0]     nar;
    logic [OUT_W-1:0]   nar_data;
    logic               nar_ovf;

    // Range check plus truncate/saturate; returns {ovf, result}.
    // Signed fits when the top IN_W-OUT_W+1 bits are a pure sign extension;
    // unsigned fits when the top IN_W-OUT_W bits are zero.
    function automatic logic [OUT_W:0] narrow_word(input logic [IN_W-1:0] d,
                                                   input logic            sgn,
                                                   input logic            sat);
        logic             fits;
        logic [OUT_W-1:0] res;
        if (sgn) begin
            fits = (&d[IN_W-1:OUT_W-1]) | ~(|d[IN_W-1:OUT_W-1]);
        end else begin
            fits = ~(|d[IN_W-1:OUT_W]);
        end
        res = d[OUT_W-1:0];
        if (!fits && sat) begin
            if (sgn) begin
                res = d[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                res = {OUT_W{1'b1}};
            end
        end
        return {~fits, res};
    endfunction

    assign nar      = narrow_word(in_data, in_signed, in_sat);
    assign nar_data = nar[OUT_W-1:0];
    assign nar_ovf  = nar[OUT_W];

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_count = cnt_q;

    // Next-state and buffer steering: where the incoming word lands and when the skid drains.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        skid_data_d = skid_data_q;
        skid_ovf_d  = skid_ovf_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d    = ST_ONE;
                    out_data_d = nar_data;
                    out_ovf_d  = nar_ovf;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    out_data_d = nar_data;
                    out_ovf_d  = nar_ovf;
                end else if (in_fire) begin
                    state_d     = ST_TWO;
                    skid_data_d = nar_data;
                    skid_ovf_d  = nar_ovf;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d    = ST_ONE;
                    out_data_d = skid_data_q;
                    out_ovf_d  = skid_ovf_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Registered ready: looks only at where we are going, never at out_ready directly.
        in_ready_d = (state_d != ST_TWO);
    end

    // Overflow event counter: clear wins over hold, but a same-cycle overflow still counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = (in_fire && nar_ovf) ? CNT_W'(1) : '0;
        end else if (in_fire && nar_ovf && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Control state: occupancy, registered ready and the event counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    // Data registers: output word and skid word, each with its overflow flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            skid_data_q <= '0;
            skid_ovf_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            skid_data_q <= skid_data_d;
            skid_ovf_q  <= skid_ovf_d;
        end
    end

endmodule

// File: tb/tb_word_narrow_unit.sv
// tb_word_narrow_unit
// Scoreboard bench for word_narrow_unit: expected {ovf, data} pushed on every
// input transfer, popped and compared on every output transfer.
module tb_word_narrow_unit;

    localparam int CNT_W = 4;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_signed = 1'b0;
    logic              in_sat = 1'b0;
    logic              out_ready = 1'b0;
    logic              clr_count = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ovf;
    logic [15:0]       out_data;
    logic [CNT_W-1:0]  ovf_count;

    int                n_chk = 0;
    int                n_pass = 0;
    logic [16:0]       sbq[$];
    logic [16:0]       sb_e;
    logic [CNT_W-1:0]  cnt_m = '0;
    logic              rnd_mode = 1'b0;

    logic              s_in_fire = 1'b0;
    logic              s_out_fire = 1'b0;
    logic              s_clr = 1'b0;
    logic [16:0]       s_in_exp = '0;
    logic [16:0]       s_out_got = '0;
    logic              stall_q = 1'b0;
    logic [16:0]       stall_val = '0;

    logic [31:0]       bnd [8] = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_7FFF, 32'hFFFF_8000,
                                   32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    always #5 Clk = ~Clk;

    word_narrow_unit #(.IN_W(32), .OUT_W(16), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference narrowing via integer range comparison.
    function automatic logic [16:0] model(input logic [31:0] d, input logic sgn, input logic sat);
        longint      v;
        logic        ovf;
        logic [15:0] r;
        if (sgn) begin
            v   = longint'($signed(d));
            ovf = (v < -32768) || (v > 32767);
        end else begin
            v   = longint'(d);
            ovf = (v > 65535);
        end
        r = d[15:0];
        if (ovf && sat) r = sgn ? ((v < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
        return {ovf, r};
    endfunction

    // Sample handshakes mid-cycle; also check the output holds while stalled.
    always @(negedge Clk) begin
        s_in_fire  = Rst_n && in_valid && in_ready;
        s_in_exp   = model(in_data, in_signed, in_sat);
        s_out_fire = Rst_n && out_valid && out_ready;
        s_out_got  = {out_ovf, out_data};
        s_clr      = clr_count;
        if (Rst_n && stall_q && out_valid) chk("stall_stable", 32'(s_out_got), 32'(stall_val));
        stall_q   = Rst_n && out_valid && !out_ready;
        stall_val = s_out_got;
    end

    // Scoreboard and counter model, committed at the edge where the transfers happen.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sbq.delete();
            cnt_m = '0;
        end else begin
            if (s_out_fire) begin
                if (sbq.size() == 0) begin
                    chk("sb_depth", 32'(sbq.size()), 32'd1);
                end else begin
                    sb_e = sbq.pop_front();
                    chk("out_word", 32'(s_out_got), 32'(sb_e));
                end
            end
            if (s_in_fire) sbq.push_back(s_in_exp);
            if (s_clr) cnt_m = (s_in_fire && s_in_exp[16]) ? CNT_W'(1) : '0;
            else if (s_in_fire && s_in_exp[16] && cnt_m != {CNT_W{1'b1}}) cnt_m = cnt_m + 1'b1;
        end
    end

    // Random downstream backpressure during the stream phase.
    always @(posedge Clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic sgn, input logic sat);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = sgn;
        in_sat    = sat;
        do begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end while (!acc && n < 500);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] r;
        int          n;

        // Reset state
        cycles(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        Rst_n = 1'b1;
        cycles(1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Signed saturating stream
        out_ready = 1'b1;
        send(32'hFFFF_8000, 1'b1, 1'b1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h8000);
        send(32'h0000_7FFF, 1'b1, 1'b1);
        send(32'h0000_8000, 1'b1, 1'b1);
        chk("sgn_pos_sat", 32'({out_ovf, out_data}), 32'h1_7FFF);
        send(32'hFFFF_7FFF, 1'b1, 1'b1);
        chk("sgn_neg_sat", 32'({out_ovf, out_data}), 32'h1_8000);
        in_valid = 1'b0;
        cycles(2);
        chk("cnt_signed", 32'(ovf_count), 32'd2);

        // Unsigned mode
        send(32'h0001_2345, 1'b0, 1'b1);
        chk("uns_sat", 32'({out_ovf, out_data}), 32'h1_FFFF);
        send(32'h0001_2345, 1'b0, 1'b0);
        chk("uns_trunc", 32'({out_ovf, out_data}), 32'h1_2345);
        send(32'h0000_FFFF, 1'b0, 1'b0);
        chk("uns_fit", 32'({out_ovf, out_data}), 32'h0_FFFF);
        in_valid = 1'b0;
        cycles(2);
        chk("cnt_unsigned", 32'(ovf_count), 32'd4);

        // Backpressure: A, B accepted, C blocked until the first drain
        out_ready = 1'b0;
        in_signed = 1'b1;
        in_sat    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0A0A;
        cycles(1);
        in_data = 32'h0000_0B0B;
        cycles(1);
        chk("bp_ready_low", 32'(in_ready), 32'd0);
        in_data = 32'h0000_0C0C;
        cycles(3);
        chk("bp_ready_hold", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(out_data), 32'h0A0A);
        out_ready = 1'b1;
        cycles(1);
        chk("bp_ready_rise", 32'(in_ready), 32'd1);
        chk("bp_second", 32'(out_data), 32'h0B0B);
        cycles(1);
        in_valid = 1'b0;
        chk("bp_third_valid", 32'(out_valid), 32'd1);
        chk("bp_third", 32'(out_data), 32'h0C0C);
        cycles(2);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Counter saturation and clear interplay
        clr_count = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        chk("cnt_clr", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 20; i++) send(32'h8000_0000 | 32'(i), 1'b1, 1'b1);
        in_valid = 1'b0;
        cycles(2);
        chk("cnt_sat", 32'(ovf_count), 32'd15);
        clr_count = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0010_0000;
        in_signed = 1'b0;
        in_sat    = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        in_valid  = 1'b0;
        chk("cnt_clr_ovf", 32'(ovf_count), 32'd1);
        clr_count = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        chk("cnt_clr_alone", 32'(ovf_count), 32'd0);
        cycles(2);

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(32'h0002_0000, 1'b1, 1'b1);
        send(32'hFFFE_0000, 1'b1, 1'b1);
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(ovf_count), 32'd2);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ovf", 32'(out_ovf), 32'd0);
        chk("arst_count", 32'(ovf_count), 32'd0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        chk("arst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        cycles(4);
        chk("arst_no_stale", 32'(out_valid), 32'd0);

        // Random stream against the reference model
        rnd_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cycles(1);
            end
            r = $urandom;
            case ($urandom_range(0, 4))
                0:       d = $urandom;
                1:       d = {{16{r[15]}}, r[15:0]};
                2:       d = {16'h0000, r[15:0]};
                3:       d = bnd[$urandom_range(0, 7)];
                default: d = {{15{r[31]}}, r[16:0]};
            endcase
            send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_mode = 1'b0;
        @(posedge Clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            cycles(1);
            n++;
        end
        cycles(1);
        chk("rnd_drain", 32'(sbq.size()), 32'd0);
        chk("rnd_count", 32'(ovf_count), 32'(cnt_m));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/word_narrow_unit.md
# word_narrow_unit

Streaming 32-to-16-bit narrowing unit, the inverse of the datapath's 16-to-32 sign/zero extension. It accepts 32-bit words on a valid/ready handshake and checks whether each word is representable in 16 bits (signed or unsigned). It emits the low half-word, either truncated or saturated, with a per-word overflow flag. It sits in front of halfword store and immediate-packing paths and keeps a saturating overflow event counter for debug.

## Interface
- IN_W, 32, input word width; fixed at 32 for this block.
- OUT_W, 16, output word width; fixed at 16.
- CNT_W, 16, width of the overflow event counter.

Ports:
- Clk, input, 1, single clock; all state updates on rising edge.
- Rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input word present.
- in_ready, output, 1, unit can accept a word this cycle.
- in_data, input, 32, word to narrow.
- in_signed, input, 1, 1 selects signed range check, 0 selects unsigned; sampled with in_data.
- in_sat, input, 1, 1 saturates on overflow, 0 truncates; sampled with in_data.
- out_valid, output, 1, output word present.
- out_ready, input, 1, downstream accepts the output word.
- out_data, output, 16, narrowed word.
- out_ovf, output, 1, the word in out_data did not fit in 16 bits.
- clr_count, input, 1, synchronous clear of ovf_count.
- ovf_count, output, CNT_W, number of accepted words that overflowed; saturates.

## Operation
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- Fit check, computed on in_data:
  - Signed: fits iff in_data[31:15] is all-0 or all-1.
  - Unsigned: fits iff in_data[31:16] == 0.
- If the word fits: result = in_data[15:0], ovf = 0.
- If the word does not fit: ovf = 1, and the result depends on the mode:
  - in_sat = 0: result = in_data[15:0] (truncate).
  - in_sat = 1, signed: result = 16'h7FFF if in_data[31] == 0, else 16'h8000.
  - in_sat = 1, unsigned: result = 16'hFFFF.
- Buffering uses an output register plus one skid register.
- State machine, encoded by occupancy:
  - EMPTY: in_ready = 1, out_valid = 0.
  - ONE: output register full; in_ready = 1, out_valid = 1.
  - TWO: output and skid registers full; in_ready = 0, out_valid = 1.
- Transitions:
  - EMPTY → ONE on input transfer.
  - ONE → EMPTY on output transfer without input transfer.
  - ONE → ONE on simultaneous input and output transfer; the new word loads the output register.
  - ONE → TWO on input transfer without output transfer; the new word goes to the skid register.
  - TWO → ONE on output transfer; the skid register moves to the output register.
- in_ready is registered, derived from next state != TWO. It must not depend combinationally on out_ready.
- out_data and out_ovf hold stable while out_valid = 1 and out_ready = 0.
- Words leave in acceptance order. No word is dropped or duplicated.
- Counter: ovf_count increments by 1 on each input transfer whose ovf = 1. It holds at 2^CNT_W − 1 and never wraps.
  - clr_count alone: ovf_count = 0 next cycle.
  - clr_count with an overflowing input transfer in the same cycle: ovf_count = 1.

## Timing
- Reset values (asserted asynchronously on Rst_n low): state EMPTY, out_valid 0, out_data 16'h0000, out_ovf 0, ovf_count 0.
- in_ready reads 1 after reset release.
- Latency is 1 cycle: a word accepted at edge N is on out_data after edge N (cycle N+1) when the unit was EMPTY or the output register emptied at edge N.
- Throughput is 1 word/cycle with out_ready held high.
- Backpressure:
  - With out_ready low, at most 2 words are accepted.
  - in_ready drops the cycle after the second acceptance.
  - in_ready rises the cycle after the first output transfer.
- Rst_n asserted mid-stream discards both buffered words. The counter clears. No output transfer occurs after reset.

## Test plan
- Signed fit, in_signed = 1, in_sat = 1, words 32'hFFFF8000, 32'h00007FFF, 32'h00008000, 32'hFFFF7FFF, out_ready high → out 8000/0, 7FFF/0, 7FFF/1, 8000/1 on consecutive cycles; ovf_count = 2.
- Unsigned mode, in_signed = 0, word 32'h0001_2345 → in_sat = 1 gives FFFF/1; in_sat = 0 gives 2345/1. Word 32'h0000_FFFF → FFFF/0.
- Backpressure: out_ready low, offer 3 words A, B, C back-to-back → A, B accepted and in_ready = 0 on the third cycle. Raise out_ready → A, B, C delivered in order with no gaps once streaming.
- Counter saturation with CNT_W = 4: 20 overflowing words → ovf_count stops at 15. clr_count plus an overflowing transfer in the same cycle → 1. clr_count alone → 0.
- Reset mid-operation: state TWO with out_ready low, pulse Rst_n low asynchronously between edges → out_valid, out_ovf, ovf_count drop to 0 immediately; in_ready = 1 after release; no stale word appears.
- Random stream of 10k words with random in_valid/out_ready against a reference model → exact data/ovf match, order preserved, out_data stable while stalled.
